// File: rtl/fnd_time_display.sv
// rtl/fnd_time_display.sv - 4-digit multiplexed seven-segment driver for the game timer.
// Latches one timer snapshot per scan frame so digits never tear on a rollover.
module fnd_time_display #(
  parameter int SCAN_DIV  = 100_000,
  parameter int BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sec0,
  input  logic [3:0] sec1,
  input  logic [3:0] min0,
  input  logic [3:0] min1,
  input  logic       time_over,
  input  logic       run,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_MAX  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_ph_q, blink_ph_d;
  logic [3:0]    s0_q, s0_d, s1_q, s1_d, m0_q, m0_d, m1_q, m1_d;
  logic          to_q, to_d, rn_q, rn_d;
  logic [3:0]    fnd_com_q, fnd_com_d;
  logic [7:0]    fnd_data_q, fnd_data_d;

  logic [3:0]    digit;
  logic [7:0]    seg;
  logic          dp_on;

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 8'hC0;
      4'd1:    seg_decode = 8'hF9;
      4'd2:    seg_decode = 8'hA4;
      4'd3:    seg_decode = 8'hB0;
      4'd4:    seg_decode = 8'h99;
      4'd5:    seg_decode = 8'h92;
      4'd6:    seg_decode = 8'h82;
      4'd7:    seg_decode = 8'hF8;
      4'd8:    seg_decode = 8'h80;
      4'd9:    seg_decode = 8'h90;
      default: seg_decode = 8'hBF;
    endcase
  endfunction

  always_comb begin
    scan_cnt_d  = scan_cnt_q + 1'b1;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q + 1'b1;
    blink_ph_d  = blink_ph_q;
    s0_d = s0_q; s1_d = s1_q; m0_d = m0_q; m1_d = m1_q;
    to_d = to_q; rn_d = rn_q;

    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
      // Snapshot loads on the same edge idx returns to 0, so slot 0 sees it.
      if (idx_q == 2'd3) begin
        s0_d = sec0; s1_d = sec1; m0_d = min0; m1_d = min1;
        to_d = time_over; rn_d = run;
      end
    end

    if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      blink_ph_d  = ~blink_ph_q;
    end
  end

  always_comb begin
    digit = s0_q;
    case (idx_q)
      2'd0: digit = s0_q;
      2'd1: digit = s1_q;
      2'd2: digit = m0_q;
      2'd3: digit = m1_q;
      default: digit = s0_q;
    endcase
    seg   = seg_decode(digit);
    dp_on = (idx_q == 2'd2) && !to_q && (!rn_q || blink_ph_q);

    fnd_com_d  = ~(4'b0001 << idx_q);
    fnd_data_d = {seg[7] & ~dp_on, seg[6:0]};
    if (to_q && !blink_ph_q) begin
      fnd_com_d  = 4'b1111;
      fnd_data_d = 8'hFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_ph_q  <= 1'b0;
      s0_q        <= 4'd0;
      s1_q        <= 4'd0;
      m0_q        <= 4'd0;
      m1_q        <= 4'd1;
      to_q        <= 1'b0;
      rn_q        <= 1'b0;
      fnd_com_q   <= 4'b1111;
      fnd_data_q  <= 8'hFF;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_ph_q  <= blink_ph_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      m0_q        <= m0_d;
      m1_q        <= m1_d;
      to_q        <= to_d;
      rn_q        <= rn_d;
      fnd_com_q   <= fnd_com_d;
      fnd_data_q  <= fnd_data_d;
    end
  end

  assign fnd_com  = fnd_com_q;
  assign fnd_data = fnd_data_q;

endmodule

// File: tb/tb_fnd_time_display.sv
// tb/tb_fnd_time_display.sv - directed bench for fnd_time_display (SCAN_DIV=4, BLINK_DIV=16).
// A frame is 16 cycles and blink_ph flips on every frame boundary.
module tb_fnd_time_display;

  logic       clk;
  logic       rst;
  logic [3:0] sec0, sec1, min0, min1;
  logic       time_over, run;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  int checks = 0;
  int passed = 0;

  fnd_time_display #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
    .clk(clk), .rst(rst),
    .sec0(sec0), .sec1(sec1), .min0(min0), .min1(min1),
    .time_over(time_over), .run(run),
    .fnd_com(fnd_com), .fnd_data(fnd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] com, input logic [7:0] data);
    checks++;
    assert (fnd_com === com && fnd_data === data) passed++;
    else $error("FAIL %s: got com=%b data=%h, expected com=%b data=%h",
                tag, fnd_com, fnd_data, com, data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [3:0] com, input logic [7:0] data);
    for (int i = 0; i < 4; i++) begin
      tick();
      check(tag, com, data);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3);
    slot({tag, "_idx0"}, 4'b1110, d0);
    slot({tag, "_idx1"}, 4'b1101, d1);
    slot({tag, "_idx2"}, 4'b1011, d2);
    slot({tag, "_idx3"}, 4'b0111, d3);
  endtask

  task automatic set_in(input logic [3:0] m1, input logic [3:0] m0, input logic [3:0] s1,
                        input logic [3:0] s0, input logic to, input logic rn);
    min1 = m1; min0 = m0; sec1 = s1; sec0 = s0; time_over = to; run = rn;
  endtask

  initial begin
    rst = 1'b1;
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    tick();
    check("reset_hold", 4'b1111, 8'hFF);
    tick();
    check("reset_hold2", 4'b1111, 8'hFF);
    rst = 1'b0;
    set_in(4'd0, 4'd9, 4'd5, 4'd9, 1'b0, 1'b0);

    // Frame 0: reset snapshot 10:00, run=0 so colon steady on.
    frame("f0_reset", 8'hC0, 8'hC0, 8'h40, 8'hF9);

    // Frame 1: 09:59; inputs change to 09:58 after slot 0 but stay invisible.
    slot("f1_idx0", 4'b1110, 8'h90);
    set_in(4'd0, 4'd9, 4'd5, 4'd8, 1'b0, 1'b0);
    slot("f1_idx1", 4'b1101, 8'h92);
    slot("f1_idx2", 4'b1011, 8'h10);
    slot("f1_idx3", 4'b0111, 8'hC0);

    // Frame 2: new 09:58 snapshot; queue 05:30 running.
    set_in(4'd0, 4'd5, 4'd3, 4'd0, 1'b0, 1'b1);
    frame("f2_0958", 8'h80, 8'h92, 8'h10, 8'hC0);

    // Frames 3..6: colon blinks with blink_ph (odd frames ph=1).
    frame("f3_blink_on",  8'hC0, 8'hB0, 8'h12, 8'hC0);
    frame("f4_blink_off", 8'hC0, 8'hB0, 8'h92, 8'hC0);
    frame("f5_blink_on",  8'hC0, 8'hB0, 8'h12, 8'hC0);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);
    frame("f6_blink_off", 8'hC0, 8'hB0, 8'h92, 8'hC0);

    // Frame 7 (ph=1): time over shows digits, dp off; frame 8 (ph=0): blank.
    frame("f7_over_show", 8'hC0, 8'hC0, 8'hC0, 8'hC0);
    set_in(4'd0, 4'd0, 4'd0, 4'hA, 1'b0, 1'b0);
    for (int s = 0; s < 4; s++) slot("f8_over_blank", 4'b1111, 8'hFF);

    // Frame 9: out-of-range digit shows dash; reset asserted mid idx2 slot.
    slot("f9_dash", 4'b1110, 8'hBF);
    slot("f9_idx1", 4'b1101, 8'hC0);
    tick();
    check("f9_idx2_a", 4'b1011, 8'h40);
    tick();
    check("f9_idx2_b", 4'b1011, 8'h40);
    rst = 1'b1;
    #1;
    check("async_reset", 4'b1111, 8'hFF);
    tick();
    check("reset_held_a", 4'b1111, 8'hFF);
    tick();
    check("reset_held_b", 4'b1111, 8'hFF);
    rst = 1'b0;

    // After release the reset snapshot 10:00 reappears from idx0.
    slot("rel_idx0", 4'b1110, 8'hC0);
    slot("rel_idx1", 4'b1101, 8'hC0);
    slot("rel_idx2", 4'b1011, 8'h40);
    slot("rel_idx3", 4'b0111, 8'hF9);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
